spi_rx_mode: RTL and testbench
==============================

// Module: spi_rx_mode
// PURPOSE
//  SPI slave receiver, oversampled by the system clock. Supports all four SPI modes and MSB/LSB-first order.
//  Accepts any number of back-to-back words per chip-select frame.
//  Completed words are buffered in an internal FIFO and handed to the consumer over a valid/ready handshake.
//  Sits between the external SPI pins and the sampling/display datapath.
// PARAMETERS
//  DATA_WIDTH  8  bits per word (>=2)
//  FIFO_DEPTH  4  buffered words; power of two, >=2
//  LSB_FIRST   0  0: first bit received -> data_out[DATA_WIDTH-1]; 1: first bit -> data_out[0]
// PORTS
//  clk_in        in   1              system clock; all logic on posedge
//  rst_in        in   1              synchronous, active-high reset
//  sclk_in       in   1              SPI clock, asynchronous to clk_in
//  sel_in        in   1              chip select, active-low, asynchronous
//  data_in       in   1              MOSI, asynchronous
//  mode_in       in   2              {CPOL,CPHA}; sampled when sel_in falls, held for the frame
//  data_out      out  DATA_WIDTH     FIFO head word
//  valid_out     out  1              FIFO not empty
//  ready_in      in   1              consumer accepts data_out when valid_out&&ready_in
//  count_out     out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  overflow_out  out  1              1-cycle pulse: word completed while FIFO full (word dropped)
//  abort_out     out  1              1-cycle pulse: sel_in rose with 0<bit count<DATA_WIDTH
// BEHAVIOUR
//  - sclk_in, sel_in and data_in each pass through a 2-flop synchronizer; edges are detected on the synced signals.
//  - Sample edge is rising for modes 0 and 3, falling for modes 1 and 2. The bit is captured on the clk_in cycle the synced edge is seen.
//  - FSM (in spi_rx_pkg): IDLE, SHIFT.
//    - IDLE -> SHIFT when synced sel falls: latch mode_in; clear shift reg and bit_cnt.
//    - SHIFT -> IDLE when synced sel rises. If 0<bit_cnt<DATA_WIDTH, pulse abort_out and discard the partial word.
//  - In SHIFT, each sample edge shifts in synced data_in and increments bit_cnt.
//    - On the DATA_WIDTH-th bit: push the assembled word in the same cycle, then set bit_cnt to 0 and keep shifting.
//    - Edges of sclk_in while sel_in is high are ignored.
//  - Word latency: word is on data_out / valid_out 1 cycle after the last-bit sample cycle (registered FIFO write, empty FIFO).
//  - FIFO: first-word fall-through.
//    - Pop on valid_out&&ready_in.
//    - Push when full: word dropped, overflow_out pulses, contents unchanged.
//    - Push and pop in the same cycle when full: pop first, push accepted, no overflow.
//    - Push and pop in the same cycle when empty: the word is not bypassed; valid_out rises next cycle.
//  - Pointers wrap modulo FIFO_DEPTH; count_out = wr-rd using an extra MSB.
//  - Reset (any time, including mid-frame or mid-word):
//    - FSM=IDLE; bit_cnt=0; FIFO empty.
//    - data_out=0, valid_out=0, count_out=0, overflow_out=0, abort_out=0.
//    - Synchronizers are cleared to sclk=0, sel=1, data=0.
//    - If sel_in is already low when reset releases, no frame starts until sel rises and falls again.
// CONFIGURATION
//  SPI_RX_STATUS_EN defined:
//   - Adds input clear_stats_in (1 bit).
//   - Adds outputs overflow_cnt_out[15:0] and abort_cnt_out[15:0], saturating at 16'hFFFF.
//   - Each counter increments on its pulse. clear_stats_in zeroes both; clear wins over a simultaneous increment.
//   - Both counters reset to 0.
//  SPI_RX_STATUS_EN undefined:
//   - These ports and counters do not exist.
//   - overflow_out and abort_out are unchanged.
// STRUCTURE
//  - spi_rx_pkg: state_t enum {IDLE,SHIFT}; spi_mode_t (2-bit); function sample_on_rise(mode) = (mode==0||mode==3).
//  - Sub-module spi_rx_fifo #(WIDTH,DEPTH): sync FWFT FIFO with push/pop/full/empty/count.
//  - Synchronizers, edge detect, FSM and shifter are inline in spi_rx_mode.
// TESTING
//  1. Mode 0, MSB-first, sel low, 8 bits of 0xA5, sel high -> one word 0xA5, valid_out high, no abort.
//  2. All modes 0-3, byte 0x3C, sclk idling at CPOL -> 0x3C received in each mode; wrong-edge sampling fails the check.
//  3. LSB_FIRST=1, one frame of 0x01,0x80,0xFF -> three words in order; count_out reaches 3 with ready_in=0.
//  4. FIFO_DEPTH=4, ready_in=0, 6 words sent -> count_out=4, two overflow_out pulses; after drain, the first 4 words in order.
//  5. sel_in rises after 5 bits, then a full 0x5A frame -> one abort_out pulse; only 0x5A is delivered.
//  6. rst_in asserted after bit 4 of a word with 2 words queued -> FIFO empty, all outputs 0; next clean frame received correctly.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the oversampled SPI slave receiver.
package spi_rx_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  typedef logic [1:0] spi_mode_t;

  // Modes 0 and 3 capture MOSI on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    return (mode == 2'd0) || (mode == 2'd3);
  endfunction
endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible while not empty.
module spi_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push_in,
  input  logic [WIDTH-1:0]           push_data_in,
  input  logic                       pop_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0]                 wr_q, wr_d, rd_q, rd_d;
  logic                        pop_ok, push_ok;

  assign empty_out = (wr_q == rd_q);
  assign full_out  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_out = wr_q - rd_q;
  assign data_out  = empty_out ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop frees the slot first, so a push into a full FIFO with a pop is accepted.
  assign pop_ok  = pop_in && !empty_out;
  assign push_ok = push_in && (!full_out || pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data_in;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop_ok) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_in) mem_q <= mem_d;
endmodule

// File: rtl/spi_rx_mode.sv
// SPI slave receiver (all four modes, MSB/LSB first) feeding a FWFT word FIFO.
// Optional SPI_RX_STATUS_EN adds saturating overflow/abort event counters.
module spi_rx_mode
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sclk_in,
  input  logic                          sel_in,
  input  logic                          data_in,
  input  logic [1:0]                    mode_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          overflow_out,
`ifdef SPI_RX_STATUS_EN
  input  logic                          clear_stats_in,
  output logic [15:0]                   overflow_cnt_out,
  output logic [15:0]                   abort_cnt_out,
`endif
  output logic                          abort_out
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [1:0]            sclk_sync_q, sclk_sync_d, sel_sync_q, sel_sync_d, mosi_sync_q, mosi_sync_d;
  logic                  sclk_prev_q, sclk_prev_d, sel_prev_q, sel_prev_d;
  logic [1:0]            live_q, live_d;
  logic                  armed_q, armed_d;
  state_t                state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  abort_q, abort_d, overflow_q, overflow_d;
  logic                  sclk_rise, sclk_fall, sel_fall, sel_rise, sample_edge;
  logic                  push, pop, fifo_full, fifo_empty;

  assign sclk_rise   = ~sclk_prev_q & sclk_sync_q[1];
  assign sclk_fall   = sclk_prev_q & ~sclk_sync_q[1];
  assign sel_rise    = ~sel_prev_q & sel_sync_q[1];
  // Falls only count once a real high level of sel has been observed after reset.
  assign sel_fall    = armed_q & sel_prev_q & ~sel_sync_q[1];
  assign sample_edge = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sclk_in};
    sel_sync_d  = {sel_sync_q[0], sel_in};
    mosi_sync_d = {mosi_sync_q[0], data_in};
    sclk_prev_d = sclk_sync_q[1];
    sel_prev_d  = sel_sync_q[1];
    // live_q[1] marks that the synchronizer output now reflects the pin, not the reset value.
    live_d      = {live_q[0], 1'b1};
    armed_d     = armed_q | (live_q[1] & sel_sync_q[1]);
    state_d     = state_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    abort_d     = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_fall) begin
          state_d   = SHIFT;
          mode_d    = mode_in;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (sel_rise) begin
          state_d   = IDLE;
          abort_d   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          if (LSB_FIRST != 0) shift_d = {mosi_sync_q[1], shift_q[DATA_WIDTH-1:1]};
          else                shift_d = {shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
          if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = push & fifo_full & ~pop;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_sync_q <= '0;
      sel_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      sel_prev_q  <= 1'b1;
      live_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      mode_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      abort_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sel_sync_q  <= sel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      sel_prev_q  <= sel_prev_d;
      live_q      <= live_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      abort_q     <= abort_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pop          = ~fifo_empty & ready_in;
  assign valid_out    = ~fifo_empty;
  assign overflow_out = overflow_q;
  assign abort_out    = abort_q;

  spi_rx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (push),
    .push_data_in (shift_d),
    .pop_in       (pop),
    .data_out     (data_out),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty),
    .count_out    (count_out)
  );

`ifdef SPI_RX_STATUS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, abt_cnt_q, abt_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    abt_cnt_d = abt_cnt_q;
    if (clear_stats_in) begin
      ovf_cnt_d = '0;
      abt_cnt_d = '0;
    end else begin
      if (overflow_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
      if (abort_q && (abt_cnt_q != 16'hFFFF))    abt_cnt_d = abt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ovf_cnt_q <= '0;
      abt_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      abt_cnt_q <= abt_cnt_d;
    end
  end

  assign overflow_cnt_out = ovf_cnt_q;
  assign abort_cnt_out    = abt_cnt_q;
`endif
endmodule

// File: tb/tb_spi_rx_mode.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share the SPI pins.
module tb_spi_rx_mode;
  localparam int W = 8, D = 4, HALF = 4, CW = $clog2(D) + 1;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, sel = 1'b1, mosi = 1'b0, ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [W-1:0] dout0, dout1;
  logic v0, v1, ovf0, ovf1, abt0, abt1;
  logic [CW-1:0] cnt0, cnt1;
`ifdef SPI_RX_STATUS_EN
  logic clr = 1'b0;
  logic [15:0] oc0, ac0, oc1, ac1;
`endif

  always #5 clk = ~clk;

  spi_rx_mode #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .LSB_FIRST(0)) u_msb (
    .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .sel_in(sel), .data_in(mosi), .mode_in(mode),
    .data_out(dout0), .valid_out(v0), .ready_in(ready), .count_out(cnt0), .overflow_out(ovf0),
`ifdef SPI_RX_STATUS_EN
    .clear_stats_in(clr), .overflow_cnt_out(oc0), .abort_cnt_out(ac0),
`endif
    .abort_out(abt0));

  spi_rx_mode #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .LSB_FIRST(1)) u_lsb (
    .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .sel_in(sel), .data_in(mosi), .mode_in(mode),
    .data_out(dout1), .valid_out(v1), .ready_in(ready), .count_out(cnt1), .overflow_out(ovf1),
`ifdef SPI_RX_STATUS_EN
    .clear_stats_in(clr), .overflow_cnt_out(oc1), .abort_cnt_out(ac1),
`endif
    .abort_out(abt1));

  int vectors = 0, miscompares = 0;
  int ovf_seen0 = 0, ovf_seen1 = 0, abt_seen0 = 0, abt_seen1 = 0, exp_ovf = 0, exp_abt = 0;
  logic [W-1:0] exp0[$], exp1[$];
  logic rand_rdy = 1'b0, partial = 1'b0;
  logic [1:0] cur_mode = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drive the non-sampled phase with the inverted bit so a wrong-edge capture shows up.
  task automatic send_bit(input logic b);
    mosi = cur_mode[0] ? ~b : b;
    ticks(HALF);
    sclk = ~sclk;
    ticks(HALF);
    mosi = cur_mode[0] ? b : ~b;
    ticks(HALF);
    sclk = ~sclk;
    ticks(HALF);
  endtask

  task automatic frame_begin(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    cur_mode = m;
    ticks(HALF);
    sel = 1'b0;
    ticks(HALF);
  endtask

  task automatic frame_end();
    ticks(HALF);
    sel = 1'b1;
    if (partial) exp_abt++;
    partial = 1'b0;
    ticks(3 * HALF);
  endtask

  // Word-level model: the first wire bit lands in the MSB (u_msb) or bit 0 (u_lsb).
  task automatic send_word(input logic [W-1:0] w, input logic wire_lsb, input int nbits);
    if (nbits == W) begin
      if (exp0.size() >= D) exp_ovf++;
      else begin
        exp0.push_back(wire_lsb ? rev(w) : w);
        exp1.push_back(wire_lsb ? w : rev(w));
      end
    end else partial = 1'b1;
    for (int i = 0; i < nbits; i++) send_bit(wire_lsb ? w[i] : w[W-1-i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && ready) begin
        if (exp0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL msb_word: got %0h, expected no word", dout0);
        end else check("msb_word", 32'(dout0), 32'(exp0.pop_front()));
      end
      if (v1 && ready) begin
        if (exp1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL lsb_word: got %0h, expected no word", dout1);
        end else check("lsb_word", 32'(dout1), 32'(exp1.pop_front()));
      end
      ovf_seen0 += int'(ovf0); ovf_seen1 += int'(ovf1);
      abt_seen0 += int'(abt0); abt_seen1 += int'(abt1);
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data0"}, 32'(dout0), 0);  check({tag, "_data1"}, 32'(dout1), 0);
    check({tag, "_valid0"}, 32'(v0), 0);    check({tag, "_valid1"}, 32'(v1), 0);
    check({tag, "_count0"}, 32'(cnt0), 0);  check({tag, "_count1"}, 32'(cnt1), 0);
    check({tag, "_ovf0"}, 32'(ovf0), 0);    check({tag, "_abt0"}, 32'(abt0), 0);
  endtask

  initial begin
    int o0, o1, a0, a1, n;
    ticks(5);
    rst = 1'b0;
    ticks(1);
    check_idle_outputs("reset");

    // single 0xA5 word in mode 0
    frame_begin(2'd0); send_word(8'hA5, 1'b0, W); frame_end();
    check("t1_valid0", 32'(v0), 1); check("t1_count0", 32'(cnt0), 1);
    check("t1_valid1", 32'(v1), 1); check("t1_abort", 32'(abt_seen0), 0);
    ready = 1'b1; ticks(4);

    // 0x3C in every mode
    for (int m = 0; m < 4; m++) begin
      frame_begin(2'(m)); send_word(8'h3C, 1'b0, W); frame_end();
    end

    // LSB-first wire order, three words held back
    ready = 1'b0;
    frame_begin(2'd0);
    send_word(8'h01, 1'b1, W); send_word(8'h80, 1'b1, W); send_word(8'hFF, 1'b1, W);
    frame_end();
    check("t3_count1", 32'(cnt1), 3); check("t3_count0", 32'(cnt0), 3);
    ready = 1'b1; ticks(8);

    // overflow: six words into a depth-4 FIFO
    ready = 1'b0; o0 = ovf_seen0; o1 = ovf_seen1;
    frame_begin(2'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) send_word(W'($urandom), 1'b0, W);
    frame_end();
    check("t4_count0", 32'(cnt0), 4); check("t4_count1", 32'(cnt1), 4);
    check("t4_ovf0", 32'(ovf_seen0 - o0), 2); check("t4_ovf1", 32'(ovf_seen1 - o1), 2);
    ready = 1'b1; ticks(10);

    // aborted partial word then a clean 0x5A
    a0 = abt_seen0; a1 = abt_seen1;
    frame_begin(2'd1); send_word(W'($urandom), 1'b0, 5); frame_end();
    frame_begin(2'd1); send_word(8'h5A, 1'b0, W); frame_end();
    check("t5_abort0", 32'(abt_seen0 - a0), 1); check("t5_abort1", 32'(abt_seen1 - a1), 1);

    // reset mid-word with two words queued
    ready = 1'b0;
    frame_begin(2'd2);
    send_word(W'($urandom), 1'b0, W); send_word(W'($urandom), 1'b0, W);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    check("t6_count_before", 32'(cnt0), 2);
    rst = 1'b1; ticks(2); rst = 1'b0;
    exp0.delete(); exp1.delete();
    ticks(1);
    check_idle_outputs("t6_reset");
    for (int i = 0; i < W; i++) send_bit(1'b1);
    check("t6_no_frame0", 32'(cnt0), 0); check("t6_no_frame1", 32'(cnt1), 0);
    sel = 1'b1; ticks(3 * HALF);
    frame_begin(2'd0); send_word(8'hC3, 1'b0, W); frame_end();
    check("t6_count_after", 32'(cnt0), 1);
    ready = 1'b1; ticks(6);

    // randomized frames with random back-pressure
    rand_rdy = 1'b1;
    repeat (30) begin
      frame_begin(2'($urandom_range(0, 3)));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) send_word(W'($urandom), 1'($urandom), W);
      if ($urandom_range(0, 4) == 0) send_word(W'($urandom), 1'b0, $urandom_range(1, W - 1));
      frame_end();
    end
    rand_rdy = 1'b0; ready = 1'b1;
    for (int i = 0; i < 200 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
    ticks(4);
    check("drain_msb", 32'(exp0.size()), 0); check("drain_lsb", 32'(exp1.size()), 0);
    check("total_ovf0", 32'(ovf_seen0), 32'(exp_ovf)); check("total_ovf1", 32'(ovf_seen1), 32'(exp_ovf));
    check("total_abt0", 32'(abt_seen0), 32'(exp_abt)); check("total_abt1", 32'(abt_seen1), 32'(exp_abt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
